// File: rtl/spi_flash_arbiter.sv
// Round-robin arbiter and register sequencer for spi_flash_ip.
// Optional poll timeout: define SPI_ARB_TIMEOUT_EN.
`timescale 1ns/1ps
module spi_flash_arbiter #(
  parameter logic [31:0] CTRL_CFG       = 32'h3,
  parameter logic [31:0] CLKDIV         = 32'h10,
  parameter int unsigned POLL_GAP       = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  input  logic [15:0] req_cmd,
  input  logic [15:0] req_len,
  output logic [1:0]  req_done,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic        ip_wr_en,
  output logic        ip_rd_en,
  output logic [7:0]  ip_addr,
  output logic [31:0] ip_wdata,
  input  logic [31:0] ip_rdata
);

  localparam int unsigned CntMax =
    (TIMEOUT_CYCLES > POLL_GAP) ? TIMEOUT_CYCLES : POLL_GAP;
  localparam int CW = $clog2(CntMax + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_GRANT, S_W_CTRL, S_W_DIV, S_W_LEN,
    S_W_TX, S_W_START, S_GAP, S_POLL, S_CHK,
    S_RD_RX, S_CAP, S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic            last_q, last_d;
  logic            gnt_q, gnt_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [7:0]      len_q, len_d;
  logic [CW-1:0]   gap_q, gap_d;
  logic [31:0]     resp_q, resp_d;
  logic            err_q, err_d;
`ifdef SPI_ARB_TIMEOUT_EN
  logic [CW-1:0]   tmo_q, tmo_d;
`endif

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      cmd_q   <= '0;
      len_q   <= '0;
      gap_q   <= '0;
      resp_q  <= '0;
      err_q   <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      cmd_q   <= cmd_d;
      len_q   <= len_d;
      gap_q   <= gap_d;
      resp_q  <= resp_d;
      err_q   <= err_d;
`ifdef SPI_ARB_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  // Next-state: arbitration, register sequence, polling
  always_comb begin
    logic g;
    g       = 1'b0;
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    cmd_d   = cmd_q;
    len_d   = len_q;
    gap_d   = gap_q;
    resp_d  = resp_q;
    err_d   = err_q;
`ifdef SPI_ARB_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (|req_valid) begin
          g       = (&req_valid) ? ~last_q : req_valid[1];
          gnt_d   = g;
          last_d  = g;
          cmd_d   = g ? req_cmd[15:8] : req_cmd[7:0];
          len_d   = g ? req_len[15:8] : req_len[7:0];
          err_d   = 1'b0;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        if (len_q == 8'd0) begin
          resp_d  = '0;
          state_d = S_DONE;
        end else begin
          state_d = S_W_CTRL;
        end
      end
      S_W_CTRL:  state_d = S_W_DIV;
      S_W_DIV:   state_d = S_W_LEN;
      S_W_LEN:   state_d = S_W_TX;
      S_W_TX:    state_d = S_W_START;
      S_W_START: begin
        gap_d   = '0;
`ifdef SPI_ARB_TIMEOUT_EN
        tmo_d   = CW'(1);
`endif
        state_d = S_GAP;
      end
      S_GAP: begin
        if (gap_q == CW'(POLL_GAP - 1)) begin
          state_d = S_POLL;
        end else begin
          gap_d = gap_q + CW'(1);
        end
      end
      S_POLL: state_d = S_CHK;
      S_CHK: begin
        if (ip_rdata[0]) begin
          gap_d   = '0;
          state_d = S_GAP;
        end else begin
          state_d = S_RD_RX;
        end
      end
      S_RD_RX: state_d = S_CAP;
      S_CAP: begin
        resp_d  = ip_rdata;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
`ifdef SPI_ARB_TIMEOUT_EN
    if (state_q == S_GAP || state_q == S_POLL ||
        state_q == S_CHK) begin
      tmo_d = tmo_q + CW'(1);
      if (tmo_q >= CW'(TIMEOUT_CYCLES)) begin
        resp_d  = '0;
        err_d   = 1'b1;
        state_d = S_DONE;
      end
    end
`endif
  end

  // Moore outputs: register strobes and completion pulse
  always_comb begin
    ip_wr_en = 1'b0;
    ip_rd_en = 1'b0;
    ip_addr  = '0;
    ip_wdata = '0;
    req_done = '0;
    unique case (state_q)
      S_W_CTRL: begin
        ip_wr_en = 1'b1;
        ip_addr  = 8'h00;
        ip_wdata = CTRL_CFG;
      end
      S_W_DIV: begin
        ip_wr_en = 1'b1;
        ip_addr  = 8'h04;
        ip_wdata = CLKDIV;
      end
      S_W_LEN: begin
        ip_wr_en = 1'b1;
        ip_addr  = 8'h08;
        ip_wdata = {24'b0, len_q};
      end
      S_W_TX: begin
        ip_wr_en = 1'b1;
        ip_addr  = 8'h14;
        ip_wdata = {24'b0, cmd_q};
      end
      S_W_START: begin
        ip_wr_en = 1'b1;
        ip_addr  = 8'h0C;
        ip_wdata = 32'h1;
      end
      S_POLL: begin
        ip_rd_en = 1'b1;
        ip_addr  = 8'h10;
      end
      S_RD_RX: begin
        ip_rd_en = 1'b1;
        ip_addr  = 8'h18;
      end
      S_DONE: req_done[gnt_q] = 1'b1;
      default: ;
    endcase
  end

  assign resp_data = resp_q;
`ifdef SPI_ARB_TIMEOUT_EN
  assign resp_err  = (state_q == S_DONE) & err_q;
`else
  assign resp_err  = 1'b0 & err_q;
`endif

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Bench for spi_flash_arbiter: transaction-level model
// plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_spi_flash_arbiter;
  localparam int PG  = 4;
  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [15:0] req_cmd;
  logic [15:0] req_len;
  logic [1:0]  req_done;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        ip_wr_en;
  logic        ip_rd_en;
  logic [7:0]  ip_addr;
  logic [31:0] ip_wdata;
  logic [31:0] ip_rdata = '0;

  always #5 clk = ~clk;

  spi_flash_arbiter #(
    .CTRL_CFG(32'h3),
    .CLKDIV(32'h10),
    .POLL_GAP(PG),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_cmd(req_cmd),
    .req_len(req_len),
    .req_done(req_done),
    .resp_data(resp_data),
    .resp_err(resp_err),
    .ip_wr_en(ip_wr_en),
    .ip_rd_en(ip_rd_en),
    .ip_addr(ip_addr),
    .ip_wdata(ip_wdata),
    .ip_rdata(ip_rdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h",
               nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rxf(logic [7:0] c,
                                      logic [7:0] l);
    return {8'hD0, c, 8'h00, l};
  endfunction

  // ---------------- IP model ----------------
  int   cfg_busy  = 0;
  bit   cfg_stuck = 0;
  int   busy_left = 0;
  logic [7:0] ip_len = '0;
  logic [7:0] ip_tx  = '0;
  int   n_strobe = 0;
  int   n_stat   = 0;

  always @(posedge clk) begin
    if (ip_wr_en) begin
      if (ip_addr == 8'h08) ip_len <= ip_wdata[7:0];
      if (ip_addr == 8'h14) ip_tx <= ip_wdata[7:0];
      if (ip_addr == 8'h0C) busy_left <= cfg_busy;
    end
    if (ip_rd_en) begin
      if (ip_addr == 8'h10) begin
        ip_rdata <= {31'b0, cfg_stuck || busy_left != 0};
        if (busy_left != 0) busy_left <= busy_left - 1;
      end else if (ip_addr == 8'h18) begin
        ip_rdata <= rxf(ip_tx, ip_len);
      end
    end
    if (ip_wr_en || ip_rd_en) n_strobe <= n_strobe + 1;
    if (ip_rd_en && ip_addr == 8'h10) n_stat <= n_stat + 1;
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic        wr;
    logic        rd;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [1:0]  done;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  logic m_last;
  bit   m_indone;
  logic [31:0] m_resp;

  function automatic exp_t mk(logic wr, logic rd,
                              logic [7:0] a, logic [31:0] wd,
                              logic [1:0] dn, logic er,
                              logic [31:0] dt);
    exp_t e;
    e.wr = wr; e.rd = rd; e.addr = a; e.wdata = wd;
    e.done = dn; e.err = er; e.data = dt;
    return e;
  endfunction

  // Expected per-cycle outputs from GRANT through DONE.
  function automatic void build(logic g, logic [7:0] c,
                                logic [7:0] l);
    logic [1:0] dn;
    int L, n;
    bit to;
    dn = g ? 2'b10 : 2'b01;
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    if (l == 8'd0) begin
      q.push_back(mk(0, 0, 0, 0, dn, 0, 0));
      return;
    end
    q.push_back(mk(1, 0, 8'h00, 32'h3, 0, 0, 0));
    q.push_back(mk(1, 0, 8'h04, 32'h10, 0, 0, 0));
    q.push_back(mk(1, 0, 8'h08, {24'b0, l}, 0, 0, 0));
    q.push_back(mk(1, 0, 8'h14, {24'b0, c}, 0, 0, 0));
    q.push_back(mk(1, 0, 8'h0C, 32'h1, 0, 0, 0));
    L  = cfg_stuck ? (1 << 20) : (cfg_busy + 1) * (PG + 2);
    n  = L;
    to = 0;
`ifdef SPI_ARB_TIMEOUT_EN
    if (L >= TMO) begin
      n  = TMO;
      to = 1;
    end
`endif
    for (int j = 0; j < n; j++) begin
      if (j % (PG + 2) == PG)
        q.push_back(mk(0, 1, 8'h10, 0, 0, 0, 0));
      else
        q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    end
    if (to) begin
      q.push_back(mk(0, 0, 0, 0, dn, 1, 0));
    end else begin
      q.push_back(mk(0, 1, 8'h18, 0, 0, 0, 0));
      q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
      q.push_back(mk(0, 0, 0, 0, dn, 0, rxf(c, l)));
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    exp_t e;
    logic g;
    bit   nd;
    if (!rst_n) begin
      q.delete();
      cur      <= mk(0, 0, 0, 0, 0, 0, 0);
      m_last   <= 1'b1;
      m_indone <= 1'b0;
      m_resp   <= '0;
    end else begin
      e  = mk(0, 0, 0, 0, 0, 0, 0);
      nd = 0;
      if (!m_indone && q.size() == 0 && req_valid != 0) begin
        g = (&req_valid) ? ~m_last : req_valid[1];
        m_last <= g;
        build(g, g ? req_cmd[15:8] : req_cmd[7:0],
              g ? req_len[15:8] : req_len[7:0]);
      end
      if (!m_indone && q.size() != 0) begin
        e  = q.pop_front();
        nd = (e.done != 0);
        if (nd) m_resp <= e.data;
      end
      cur      <= e;
      m_indone <= nd;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    chk("ip_wr_en", 32'(ip_wr_en), 32'(cur.wr));
    chk("ip_rd_en", 32'(ip_rd_en), 32'(cur.rd));
    chk("ip_addr", 32'(ip_addr), 32'(cur.addr));
    chk("ip_wdata", ip_wdata, cur.wdata);
    chk("req_done", 32'(req_done), 32'(cur.done));
    chk("resp_data", resp_data, m_resp);
    if (cur.done != 0)
      chk("resp_err", 32'(resp_err), 32'(cur.err));
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_done(output int lat,
                           output logic [1:0] d);
    lat = 0;
    d   = '0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      lat++;
      if (req_done != 0) begin
        d = req_done;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL wait_done: no req_done within 400 cycles");
  endtask

  task automatic outs_zero(string nm);
    chk({nm, "_done"}, 32'(req_done), 0);
    chk({nm, "_data"}, resp_data, 0);
    chk({nm, "_err"}, 32'(resp_err), 0);
    chk({nm, "_strb"}, 32'({ip_wr_en, ip_rd_en}), 0);
    chk({nm, "_addr"}, 32'(ip_addr), 0);
    chk({nm, "_wdata"}, ip_wdata, 0);
  endtask

  initial begin
    int lat;
    int s0, t0;
    bit hit;
    logic [1:0] d;
    rst_n     = 1'b0;
    req_valid = '0;
    req_cmd   = '0;
    req_len   = '0;
    repeat (3) @(negedge clk);
    outs_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // single req0, busy for 3 polls
    cfg_busy  = 3;
    req_cmd   = 16'h0003;
    req_len   = 16'h0004;
    s0        = n_stat;
    req_valid = 2'b01;
    wait_done(lat, d);
    chk("t1_latency", lat, 33);
    chk("t1_done", 32'(d), 32'h1);
    chk("t1_data", resp_data, 32'hD003_0004);
    chk("t1_status_reads", n_stat - s0, 4);
    req_valid = '0;
    @(negedge clk);

    // both requesters valid from reset, held
    rst_n     = 1'b0;
    cfg_busy  = 0;
    req_cmd   = 16'h2211;
    req_len   = 16'h0302;
    req_valid = 2'b11;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_done(lat, d);
      chk("t2_grant", 32'(d), (k % 2) ? 32'h2 : 32'h1);
      chk("t2_data", resp_data,
          (k % 2) ? 32'hD022_0003 : 32'hD011_0002);
    end
    req_valid = '0;
    @(negedge clk);

    // req1 with zero length
    req_cmd   = 16'h4400;
    req_len   = 16'h0000;
    t0        = n_strobe;
    req_valid = 2'b10;
    wait_done(lat, d);
    chk("t3_latency", lat, 2);
    chk("t3_done", 32'(d), 32'h2);
    chk("t3_data", resp_data, 0);
    chk("t3_strobes", n_strobe - t0, 0);
    req_valid = '0;
    @(negedge clk);

    // reset during W_LEN, req0 still valid
    cfg_busy  = 1;
    req_cmd   = 16'h009F;
    req_len   = 16'h0004;
    req_valid = 2'b01;
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      hit = ip_wr_en && ip_addr == 8'h08;
    end
    chk("t4_reach_wlen", 32'(hit), 1);
    #2 rst_n = 1'b0;
    #1 outs_zero("t4_async");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      hit = ip_wr_en;
    end
    chk("t4_first_addr", 32'(ip_addr), 32'h00);
    chk("t4_first_wdata", ip_wdata, 32'h3);
    wait_done(lat, d);
    chk("t4_done", 32'(d), 32'h1);
    chk("t4_data", resp_data, 32'hD09F_0004);
    req_valid = '0;
    @(negedge clk);

`ifdef SPI_ARB_TIMEOUT_EN
    // IP stuck busy, then a normal request
    cfg_stuck = 1;
    req_cmd   = 16'h0005;
    req_len   = 16'h0008;
    req_valid = 2'b01;
    wait_done(lat, d);
    chk("t5_latency", lat, 71);
    chk("t5_err", 32'(resp_err), 1);
    chk("t5_data", resp_data, 0);
    req_valid = '0;
    @(negedge clk);
    cfg_stuck = 0;
    cfg_busy  = 0;
    req_cmd   = 16'h0006;
    req_len   = 16'h0002;
    req_valid = 2'b01;
    wait_done(lat, d);
    chk("t5b_err", 32'(resp_err), 0);
    chk("t5b_data", resp_data, 32'hD006_0002);
    req_valid = '0;
    @(negedge clk);
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
